pwm8: RTL and testbench

- 8-bit free-running pulse-width modulator.
- Produces one registered output, PWM_sig, with a period of 256 clocks.
- PWM_sig is high for exactly `duty` clocks per period, starting at the period boundary.
- Used as a leaf block driving motor/LED/actuator enables from an 8-bit duty word supplied by control logic.

---
 rtl/pwm8.sv | 26 ++
 tb/tb_pwm8.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pwm8.sv
// 8-bit free-running PWM: 256-clock period, output high while the counter is below duty.
// The output comes straight from a flop so it is glitch-free for downstream enables.
module pwm8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty,
    output logic       PWM_sig
);

    logic [7:0] cntr;
    logic [7:0] cntr_next;

    assign cntr_next = cntr + 8'd1;

    // Compare against the next count so PWM_sig and cntr move on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cntr    <= 8'h00;
            PWM_sig <= 1'b0;
        end else begin
            cntr    <= cntr_next;
            PWM_sig <= (cntr_next < duty);
        end
    end

endmodule

// File: tb/tb_pwm8.sv
// Bench for pwm8: a per-cycle reference model feeds an expected queue, plus
// per-period pulse-width and rise-spacing measurements for the directed cases.
module tb_pwm8;

    logic       clk;
    logic       rst_n;
    logic [7:0] duty;
    logic       PWM_sig;

    pwm8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (duty),
        .PWM_sig (PWM_sig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [7:0] m_cnt = 8'h00;
    logic       m_pwm = 1'b0;

    int cyc       = 0;
    int highs     = 0;
    int last_rise = -1;
    int rise_gap  = 0;
    logic prev_pwm = 1'b0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one cycle: predict the post-edge state, then compare after the edge.
    task automatic tick(input logic rst_v, input logic [7:0] duty_v);
        logic [8:0] exp;
        rst_n = rst_v;
        duty  = duty_v;
        if (!rst_v) begin
            m_cnt = 8'h00;
            m_pwm = 1'b0;
        end else begin
            m_cnt = m_cnt + 8'd1;
            m_pwm = (m_cnt < duty_v);
        end
        exp_q.push_back({m_cnt, m_pwm});
        @(posedge clk);
        #1;
        cyc++;
        exp = exp_q.pop_front();
        check_eq("cycle", {7'd0, dut.cntr, PWM_sig}, {7'd0, exp});
        if (PWM_sig === 1'b1) highs++;
        if (PWM_sig === 1'b1 && prev_pwm !== 1'b1) begin
            if (last_rise >= 0) rise_gap = cyc - last_rise;
            last_rise = cyc;
        end
        prev_pwm = PWM_sig;
    endtask

    // Run until the DUT counter reaches target, bounded so a stuck counter cannot hang.
    task automatic run_until(input logic [7:0] duty_v, input logic [7:0] target);
        int n;
        n = 0;
        while (dut.cntr !== target && n < 600) begin
            tick(1'b1, duty_v);
            n++;
        end
        if (n >= 600) check_eq("run_until_timeout", {8'd0, dut.cntr}, {8'd0, target});
    endtask

    // One full period starting from cntr==FF; returns clocks high.
    task automatic run_period(input logic [7:0] duty_v, output int h);
        highs = 0;
        for (int i = 0; i < 256; i++) tick(1'b1, duty_v);
        h = highs;
    endtask

    initial begin
        int h;
        rst_n = 1'b0;
        duty  = 8'h05;

        // Reset holds counter and output at zero.
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h05);
        check_eq("reset_cntr", {8'd0, dut.cntr}, 16'h0000);
        check_eq("reset_pwm", {15'd0, PWM_sig}, 16'h0000);

        // Basic duty 5: first period is 255 clocks, then high for cntr 0..4.
        tick(1'b1, 8'h05);
        check_eq("first_edge_cntr", {8'd0, dut.cntr}, 16'h0001);
        run_until(8'h05, 8'hFF);
        highs = 0;
        for (int i = 0; i < 8; i++) tick(1'b1, 8'h05);
        check_eq("basic_pwm_low", {15'd0, PWM_sig}, 16'h0000);
        check_eq("basic_cntr", {8'd0, dut.cntr}, 16'h0007);
        check_eq("basic_high", h[15:0] & 16'h0 | highs[15:0], 16'd5);
        run_until(8'h80, 8'hFF);

        // Duty 0x80 over three periods.
        for (int p = 0; p < 3; p++) begin
            run_period(8'h80, h);
            check_eq("half_high", h[15:0], 16'd128);
            if (p > 0) check_eq("half_rise_gap", rise_gap[15:0], 16'd256);
        end

        // Extremes.
        highs = 0;
        for (int i = 0; i < 512; i++) tick(1'b1, 8'h00);
        check_eq("zero_high", highs[15:0], 16'd0);
        run_period(8'hFF, h);
        check_eq("full_high", h[15:0], 16'd255);
        check_eq("full_low_at_ff", {15'd0, PWM_sig}, 16'h0000);
        run_period(8'h01, h);
        check_eq("one_high", h[15:0], 16'd1);

        // Mid-period change from 0x10 to 0x04 at cntr==8.
        run_until(8'h10, 8'h08);
        check_eq("mid_pre_pwm", {15'd0, PWM_sig}, 16'h0001);
        tick(1'b1, 8'h04);
        check_eq("mid_fall", {15'd0, PWM_sig}, 16'h0000);
        run_until(8'h04, 8'hFF);
        run_period(8'h04, h);
        check_eq("mid_next_high", h[15:0], 16'd4);

        // Reset mid-operation at cntr==0x40.
        run_until(8'h80, 8'h40);
        tick(1'b0, 8'h80);
        check_eq("midrst_pwm", {15'd0, PWM_sig}, 16'h0000);
        check_eq("midrst_cntr", {8'd0, dut.cntr}, 16'h0000);
        highs = 0;
        run_until(8'h80, 8'hFF);
        check_eq("midrst_first_high", highs[15:0], 16'd127);
        run_period(8'h80, h);
        check_eq("midrst_next_high", h[15:0], 16'd128);

        check_eq("queue_drained", exp_q.size(), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
